mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported, word-addressed backing memory between the Riscv151 instruction port (icache_*) and data port (dcache_*).
- Presents the same synchronous-read timing the core expects and drives the core's `stall` input while the shared port is busy.
- A one-entry fetch buffer keeps the core from re-fetching the same PC every cycle while it is stalled.
- Sits between the core and the memory model or controller.

Parameters:
- ADDR_W, 30: word-address width of the backing memory port.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- icache_re  in  1  instruction read request.
- icache_addr  in  32  instruction byte address; bits [ADDR_W+1:2] are used.
- icache_dout  out  32  instruction data, registered.
- dcache_re  in  1  data read request.
- dcache_we  in  4  data byte write enables; non-zero means a write.
- dcache_addr  in  32  data word address; bits [ADDR_W-1:0] are used.
- dcache_din  in  32  store data.
- dcache_dout  out  32  load data, registered.
- stall  out  1  core stall, registered.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_rw  out  1  1 = write, 0 = read.
- mem_req_addr  out  ADDR_W  word address.
- mem_req_data  out  32  write data.
- mem_req_mask  out  4  byte mask.
- mem_resp_valid  in  1  read data valid; one pulse per read.
- mem_resp_data  in  32  read data.

Behaviour:
- Reset values (reset=0):
  - icache_dout, dcache_dout, mem_req_data, mem_req_addr and mem_req_mask are 0.
  - stall, mem_req_valid and mem_req_rw are 0.
  - Fetch buffer is invalid; state is IDLE.
- Reset mid-transaction abandons the transaction. Any later mem_resp_valid arriving in IDLE is ignored.
- States: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT.
- IDLE, sampled each cycle while stall=0:
  - Capture: dcache_we, dcache_re, dcache_addr, dcache_din, icache_re and icache_addr are latched into request registers.
  - Instruction hit: icache_re=1 and the buffer is valid with a matching address. icache_dout is reloaded from the buffer next cycle; no memory access.
  - Instruction miss: icache_re=1 without a hit. An instruction access is pending.
  - Data access: any dcache_we!=0 or dcache_re=1 is pending. Writes take precedence if both are set. A write leaves dcache_dout unchanged.
  - If any access is pending: go to D_REQ if a data access is pending, else I_REQ, and set stall=1 the next cycle.
  - If none is pending: stay in IDLE with stall=0.
- D_REQ / I_REQ:
  - mem_req_valid=1 with rw, addr, data and mask from the latched request. Fetches use rw=0, mask=4'hF.
  - Held stable until mem_req_ready=1.
  - On ready, a data write proceeds:
    - to I_REQ if an instruction miss is pending;
    - otherwise to IDLE.
  - On ready, a data read goes to D_WAIT; an instruction read goes to I_WAIT.
- D_WAIT: on mem_resp_valid, dcache_dout <= mem_resp_data. Then go to I_REQ if an instruction miss is pending, else IDLE.
- I_WAIT: on mem_resp_valid:
  - icache_dout and the buffer data <= mem_resp_data;
  - the buffer is tagged with the latched address and marked valid;
  - go to IDLE.
- stall:
  - Goes 0 in the same cycle the state returns to IDLE, with the output data already valid.
  - Core inputs are ignored whenever stall=1.
- Fetch-buffer coherence: a data write whose word address equals the buffer tag invalidates the buffer when the write is accepted.
- At most one memory transaction is outstanding.
- Minimum miss penalty with ready=1 and a response one cycle later: stall high for 3 cycles.

Test Plan:
- Reset then release with icache_re=1, addr 0x2000. The memory returns 0x00000013 one cycle after acceptance. -> Request addr 0x800, rw=0. stall is high for 3 cycles, then icache_dout=0x00000013 with stall=0.
- Repeat the same icache_addr 0x2000 for 5 cycles. -> No mem_req_valid. stall stays 0. icache_dout stays 0x00000013.
- Same cycle: dcache_re=1, addr 0x100, plus an icache miss at 0x2004. -> Data read to 0x100 is issued first, then fetch 0x801. dcache_dout and icache_dout are both valid when stall drops.
- dcache_we=4'b0011, addr 0x800, din 0xDEADBEEF, with mem_req_ready low for 4 cycles. -> Request fields are held stable. mask=0011. The buffer is invalidated, so the next fetch of 0x2000 goes to memory.
- dcache_re=1 and dcache_we=4'hF together. -> A single write only. dcache_dout is unchanged.
- Pull reset low during D_WAIT, then pulse mem_resp_valid. -> All outputs go to 0 immediately. The late response is ignored. The state is IDLE after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one word-addressed memory port between instruction and data requests; data first, then fetch.
// Stall is held while the port is busy and drops with the result registered; requests wait on mem_req_ready.
module mem_arbiter #(
    parameter int ADDR_W = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              icache_re,
    input  logic [31:0]       icache_addr,
    output logic [31:0]       icache_dout,
    input  logic              dcache_re,
    input  logic [3:0]        dcache_we,
    input  logic [31:0]       dcache_addr,
    input  logic [31:0]       dcache_din,
    output logic [31:0]       dcache_dout,
    output logic              stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [31:0]       mem_req_data,
    output logic [3:0]        mem_req_mask,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_D_REQ,
        S_D_WAIT,
        S_I_REQ,
        S_I_WAIT
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_stall;
    logic [31:0]         r_icache_dout;
    logic [31:0]         r_dcache_dout;
    logic [3:0]          r_dwe;
    logic                r_dwr;
    logic [ADDR_W-1:0]   r_daddr;
    logic [31:0]         r_ddin;
    logic                r_imiss;
    logic [ADDR_W-1:0]   r_iaddr;
    logic                r_buf_vld;
    logic [ADDR_W-1:0]   r_buf_tag;
    logic [31:0]         r_buf_dat;

    logic [ADDR_W-1:0]   w_ifetch_addr;
    logic                w_dwr_in;
    logic                w_ihit;
    logic                w_imiss_in;
    logic                w_dacc_in;
    logic                w_sample;
    logic                w_unused_bits;

    assign w_ifetch_addr = icache_addr[ADDR_W+1:2];
    assign w_dwr_in      = |dcache_we;
    assign w_ihit        = icache_re && r_buf_vld && (r_buf_tag == w_ifetch_addr);
    assign w_imiss_in    = icache_re && !w_ihit;
    assign w_dacc_in     = w_dwr_in || dcache_re;
    assign w_sample      = (r_state == S_IDLE) && !r_stall;
    assign w_unused_bits = ^{icache_addr[1:0], dcache_addr[31:ADDR_W]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_sample) begin
                    if (w_dacc_in) begin
                        w_next_state = S_D_REQ;
                    end else if (w_imiss_in) begin
                        w_next_state = S_I_REQ;
                    end
                end
            end
            S_D_REQ: begin
                if (mem_req_ready) begin
                    if (!r_dwr) begin
                        w_next_state = S_D_WAIT;
                    end else if (r_imiss) begin
                        w_next_state = S_I_REQ;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            S_D_WAIT: begin
                if (mem_resp_valid) begin
                    w_next_state = r_imiss ? S_I_REQ : S_IDLE;
                end
            end
            S_I_REQ: begin
                if (mem_req_ready) begin
                    w_next_state = S_I_WAIT;
                end
            end
            S_I_WAIT: begin
                if (mem_resp_valid) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Request fields read as zero whenever no request is presented.
    assign mem_req_valid = (r_state == S_D_REQ) || (r_state == S_I_REQ);
    assign mem_req_rw    = (r_state == S_D_REQ) && r_dwr;
    assign mem_req_addr  = (r_state == S_D_REQ) ? r_daddr :
                           (r_state == S_I_REQ) ? r_iaddr : '0;
    assign mem_req_data  = (r_state == S_D_REQ) ? r_ddin : 32'h0;
    assign mem_req_mask  = mem_req_rw ? r_dwe : (mem_req_valid ? 4'hF : 4'h0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall       <= 1'b0;
            r_icache_dout <= 32'h0;
            r_dcache_dout <= 32'h0;
            r_dwe         <= 4'h0;
            r_dwr         <= 1'b0;
            r_daddr       <= '0;
            r_ddin        <= 32'h0;
            r_imiss       <= 1'b0;
            r_iaddr       <= '0;
            r_buf_vld     <= 1'b0;
            r_buf_tag     <= '0;
            r_buf_dat     <= 32'h0;
        end else begin
            r_stall <= (w_next_state != S_IDLE);
            if (w_sample) begin
                r_dwe   <= dcache_we;
                r_dwr   <= w_dwr_in;
                r_daddr <= dcache_addr[ADDR_W-1:0];
                r_ddin  <= dcache_din;
                r_imiss <= w_imiss_in;
                r_iaddr <= w_ifetch_addr;
                if (w_ihit) begin
                    r_icache_dout <= r_buf_dat;
                end
            end
            // A store to the buffered word makes the buffered copy stale.
            if ((r_state == S_D_REQ) && mem_req_ready && r_dwr && (r_daddr == r_buf_tag)) begin
                r_buf_vld <= 1'b0;
            end
            if ((r_state == S_D_WAIT) && mem_resp_valid) begin
                r_dcache_dout <= mem_resp_data;
            end
            if ((r_state == S_I_WAIT) && mem_resp_valid) begin
                r_icache_dout <= mem_resp_data;
                r_buf_dat     <= mem_resp_data;
                r_buf_tag     <= r_iaddr;
                r_buf_vld     <= 1'b1;
            end
        end
    end

    assign icache_dout = r_icache_dout;
    assign dcache_dout = r_dcache_dout;
    assign stall       = r_stall;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences and random ops
// checked against a transaction-level model of the arbiter and a memory responder.
module tb_mem_arbiter;
    localparam int AW = 30;

    logic          clk = 1'b0;
    logic          reset;
    logic          icache_re;
    logic [31:0]   icache_addr;
    logic [31:0]   icache_dout;
    logic          dcache_re;
    logic [3:0]    dcache_we;
    logic [31:0]   dcache_addr;
    logic [31:0]   dcache_din;
    logic [31:0]   dcache_dout;
    logic          stall;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic [31:0]   mem_req_data;
    logic [3:0]    mem_req_mask;
    logic          mem_resp_valid;
    logic [31:0]   mem_resp_data;

    mem_arbiter #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .icache_re(icache_re), .icache_addr(icache_addr), .icache_dout(icache_dout),
        .dcache_re(dcache_re), .dcache_we(dcache_we), .dcache_addr(dcache_addr),
        .dcache_din(dcache_din), .dcache_dout(dcache_dout), .stall(stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        fetch;
    } req_t;

    typedef struct {
        logic        ire;
        logic [31:0] iaddr;
        logic        dre;
        logic [3:0]  dwe;
        logic [31:0] daddr;
        logic [31:0] din;
    } op_t;

    typedef struct {
        op_t         op;
        logic [31:0] e_i;
        logic [31:0] e_d;
        int          e_stall;
        int          e_nreq;
    } vec_t;

    req_t        log_q[$];
    req_t        exp_q[$];
    vec_t        vec_q[$];
    logic [31:0] env_mem [logic [29:0]];
    logic [31:0] mdl_mem [logic [29:0]];
    int          rdy_delay = 0;
    int          stab_err  = 0;
    int          n_chk     = 0;
    int          n_err     = 0;

    // Transaction-level model state
    logic        m_bv;
    logic [29:0] m_btag;
    logic [31:0] m_bdat;
    logic [31:0] m_idout;
    logic [31:0] m_ddout;
    int          exp_stall;

    function automatic logic [31:0] dflt(input logic [29:0] a);
        return {2'b00, a} ^ 32'hA500_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Memory responder: optional ready delay, read data one idle cycle after acceptance.
    initial begin : responder
        int          wait_cnt;
        int          resp_cnt;
        logic [31:0] resp_dat;
        logic [31:0] w;
        req_t        cur;
        req_t        snap;
        wait_cnt = 0;
        resp_cnt = 0;
        resp_dat = 0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = resp_dat;
                end
            end
            if (mem_req_valid) begin
                cur.rw = mem_req_rw; cur.addr = mem_req_addr; cur.data = mem_req_data;
                cur.mask = mem_req_mask; cur.fetch = 1'b0;
                if (wait_cnt == 0) snap = cur;
                else if (cur.rw !== snap.rw || cur.addr !== snap.addr ||
                         cur.data !== snap.data || cur.mask !== snap.mask) stab_err++;
                if (wait_cnt < rdy_delay) begin
                    mem_req_ready = 1'b0;
                    wait_cnt++;
                end else begin
                    mem_req_ready = 1'b1;
                    wait_cnt = 0;
                    log_q.push_back(cur);
                    w = env_mem.exists(cur.addr) ? env_mem[cur.addr] : dflt(cur.addr);
                    if (cur.rw) begin
                        for (int b = 0; b < 4; b++)
                            if (cur.mask[b]) w[8*b +: 8] = cur.data[8*b +: 8];
                        env_mem[cur.addr] = w;
                    end else begin
                        resp_cnt = 2;
                        resp_dat = w;
                    end
                end
            end else begin
                mem_req_ready = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // What one core request should do: data access (write wins) then fetch on a buffer miss.
    task automatic model_op(input op_t o);
        logic [29:0] ia;
        logic [29:0] da;
        logic        hit;
        logic [31:0] w;
        req_t        r;
        ia = o.iaddr[31:2];
        da = o.daddr[29:0];
        hit = o.ire && m_bv && (m_btag == ia);
        exp_stall = 0;
        if (hit) m_idout = m_bdat;
        if (o.dwe != 4'h0) begin
            r.rw = 1'b1; r.addr = da; r.data = o.din; r.mask = o.dwe; r.fetch = 1'b0;
            exp_q.push_back(r);
            w = mdl_mem.exists(da) ? mdl_mem[da] : dflt(da);
            for (int b = 0; b < 4; b++)
                if (o.dwe[b]) w[8*b +: 8] = o.din[8*b +: 8];
            mdl_mem[da] = w;
            exp_stall += 1 + rdy_delay;
            if (m_bv && m_btag == da) m_bv = 1'b0;
        end else if (o.dre) begin
            r.rw = 1'b0; r.addr = da; r.data = 32'h0; r.mask = 4'hF; r.fetch = 1'b0;
            exp_q.push_back(r);
            m_ddout = mdl_mem.exists(da) ? mdl_mem[da] : dflt(da);
            exp_stall += 3 + rdy_delay;
        end
        if (o.ire && !hit) begin
            r.rw = 1'b0; r.addr = ia; r.data = 32'h0; r.mask = 4'hF; r.fetch = 1'b1;
            exp_q.push_back(r);
            m_bdat  = mdl_mem.exists(ia) ? mdl_mem[ia] : dflt(ia);
            m_idout = m_bdat;
            m_btag  = ia;
            m_bv    = 1'b1;
            exp_stall += 3 + rdy_delay;
        end
    endtask

    // Present one request for a single sampling edge, then count stalled cycles.
    task automatic do_op(input op_t o, output int sc);
        icache_re = o.ire; icache_addr = o.iaddr; dcache_re = o.dre;
        dcache_we = o.dwe; dcache_addr = o.daddr; dcache_din = o.din;
        @(negedge clk);
        icache_re = 1'b0; dcache_re = 1'b0; dcache_we = 4'h0;
        sc = 0;
        while (stall && sc < 200) begin
            sc++;
            @(negedge clk);
        end
        if (stall) chk("stall_timeout", 32'(stall), 32'h0);
    endtask

    task automatic cmp_log(input string tag);
        chk({tag, "_nreq"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_rw%0d", tag, i), 32'(log_q[i].rw), 32'(exp_q[i].rw));
            chk($sformatf("%s_addr%0d", tag, i), 32'(log_q[i].addr), 32'(exp_q[i].addr));
            if (exp_q[i].rw || exp_q[i].fetch)
                chk($sformatf("%s_mask%0d", tag, i), 32'(log_q[i].mask), 32'(exp_q[i].mask));
            if (exp_q[i].rw)
                chk($sformatf("%s_data%0d", tag, i), log_q[i].data, exp_q[i].data);
        end
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic add_vec(input logic ire, input logic [31:0] ia, input logic dre,
                           input logic [3:0] dwe, input logic [31:0] da, input logic [31:0] din,
                           input logic [31:0] ei, input logic [31:0] ed, input int es, input int en);
        vec_t v;
        v.op.ire = ire; v.op.iaddr = ia; v.op.dre = dre; v.op.dwe = dwe;
        v.op.daddr = da; v.op.din = din;
        v.e_i = ei; v.e_d = ed; v.e_stall = es; v.e_nreq = en;
        vec_q.push_back(v);
    endtask

    initial begin : main
        int   sc;
        int   r;
        op_t  o;
        vec_t v;

        add_vec(1, 32'h2000, 0, 4'h0, 32'h0,   32'h0,        32'h13,       32'h0,        3, 1);
        for (int i = 0; i < 5; i++)
            add_vec(1, 32'h2000, 0, 4'h0, 32'h0, 32'h0,      32'h13,       32'h0,        0, 0);
        add_vec(1, 32'h2004, 1, 4'h0, 32'h100, 32'h0,        32'h0010_0093, 32'hCAFE_F00D, 6, 2);
        add_vec(0, 32'h0,    1, 4'hF, 32'h200, 32'h1122_3344, 32'h0010_0093, 32'hCAFE_F00D, 1, 1);
        add_vec(0, 32'h0,    1, 4'h0, 32'h200, 32'h0,        32'h0010_0093, 32'h1122_3344, 3, 1);
        add_vec(1, 32'h2004, 0, 4'h0, 32'h0,   32'h0,        32'h0010_0093, 32'h1122_3344, 0, 0);
        add_vec(1, 32'h2000, 0, 4'h0, 32'h0,   32'h0,        32'h13,       32'h1122_3344, 3, 1);

        env_mem[30'h800] = 32'h0000_0013; mdl_mem[30'h800] = 32'h0000_0013;
        env_mem[30'h801] = 32'h0010_0093; mdl_mem[30'h801] = 32'h0010_0093;
        env_mem[30'h100] = 32'hCAFE_F00D; mdl_mem[30'h100] = 32'hCAFE_F00D;
        m_bv = 1'b0; m_btag = '0; m_bdat = 32'h0; m_idout = 32'h0; m_ddout = 32'h0;

        reset = 1'b0;
        icache_re = 1'b0; icache_addr = 32'h0; dcache_re = 1'b0; dcache_we = 4'h0;
        dcache_addr = 32'h0; dcache_din = 32'h0;
        #1;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_valid", 32'(mem_req_valid), 32'h0);
        chk("rst_rw",    32'(mem_req_rw), 32'h0);
        chk("rst_addr",  32'(mem_req_addr), 32'h0);
        chk("rst_data",  mem_req_data, 32'h0);
        chk("rst_mask",  32'(mem_req_mask), 32'h0);
        chk("rst_idout", icache_dout, 32'h0);
        chk("rst_ddout", dcache_dout, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vec_q.size(); i++) begin
            v = vec_q[i];
            model_op(v.op);
            do_op(v.op, sc);
            chk($sformatf("v%0d_stall", i), 32'(sc), 32'(v.e_stall));
            chk($sformatf("v%0d_idout", i), icache_dout, v.e_i);
            chk($sformatf("v%0d_ddout", i), dcache_dout, v.e_d);
            chk($sformatf("v%0d_nreq", i), 32'(log_q.size()), 32'(v.e_nreq));
            cmp_log($sformatf("v%0d", i));
        end

        // Partial store to the buffered word while ready is held low.
        rdy_delay = 4;
        stab_err  = 0;
        o.ire = 0; o.iaddr = 0; o.dre = 0; o.dwe = 4'b0011; o.daddr = 32'h800; o.din = 32'hDEAD_BEEF;
        model_op(o);
        do_op(o, sc);
        chk("wr_stall", 32'(sc), 32'd5);
        chk("wr_stable", 32'(stab_err), 32'h0);
        if (log_q.size() > 0) chk("wr_mask", 32'(log_q[0].mask), 32'h3);
        cmp_log("wr");
        rdy_delay = 0;
        o.ire = 1; o.iaddr = 32'h2000; o.dwe = 4'h0;
        model_op(o);
        do_op(o, sc);
        chk("refetch_stall", 32'(sc), 32'd3);
        chk("refetch_idout", icache_dout, 32'h0000_BEEF);
        cmp_log("refetch");

        // Reset during D_WAIT, then a stale response while idle.
        dcache_re = 1'b1; dcache_addr = 32'h300;
        @(negedge clk);
        dcache_re = 1'b0;
        @(negedge clk);
        chk("dwait_stall", 32'(stall), 32'h1);
        reset = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall), 32'h0);
        chk("mid_rst_valid", 32'(mem_req_valid), 32'h0);
        chk("mid_rst_addr",  32'(mem_req_addr), 32'h0);
        chk("mid_rst_mask",  32'(mem_req_mask), 32'h0);
        chk("mid_rst_idout", icache_dout, 32'h0);
        chk("mid_rst_ddout", dcache_dout, 32'h0);
        #1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("late_resp_ddout", dcache_dout, 32'h0);
        chk("late_resp_stall", 32'(stall), 32'h0);
        chk("late_resp_valid", 32'(mem_req_valid), 32'h0);
        log_q.delete();
        m_bv = 1'b0; m_idout = 32'h0; m_ddout = 32'h0;
        o.ire = 1; o.iaddr = 32'h2004; o.dre = 0; o.dwe = 4'h0;
        model_op(o);
        do_op(o, sc);
        chk("post_rst_stall", 32'(sc), 32'd3);
        chk("post_rst_idout", icache_dout, 32'h0010_0093);
        cmp_log("post_rst");

        for (int k = 0; k < 250; k++) begin
            o.ire   = ($urandom_range(0, 9) < 6);
            o.iaddr = 32'h2000 + 32'(4 * $urandom_range(0, 7));
            r       = int'($urandom_range(0, 9));
            o.dwe   = (r < 3) ? 4'($urandom_range(1, 15)) : 4'h0;
            o.dre   = (r >= 2 && r < 6);
            o.daddr = ($urandom_range(0, 1) == 1) ? 32'h800 + 32'($urandom_range(0, 7))
                                                  : 32'h100 + 32'($urandom_range(0, 7));
            o.din   = $urandom;
            rdy_delay = int'($urandom_range(0, 2));
            model_op(o);
            do_op(o, sc);
            chk($sformatf("r%0d_stall", k), 32'(sc), 32'(exp_stall));
            chk($sformatf("r%0d_idout", k), icache_dout, m_idout);
            chk($sformatf("r%0d_ddout", k), dcache_dout, m_ddout);
            cmp_log($sformatf("r%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
